as_lsu: RTL and testbench
=========================

Name: as_lsu

Overview:
- Memory-access stage; sits directly downstream of the ID/EX-to-access pipeline register.
- Consumes that register's outputs: instruction, ALU result as address or result, rs2 store data, access flag.
- Performs the load/store on the data bus with a request/grant/response handshake.
- Stalls the pipeline while the bus is busy and presents sign/zero-extended load data or the passthrough ALU result to writeback.

Parameters:
CPU_WIDTH, 32, data/address width (fixed at 32 for byte-enable logic)
BUS_TIMEOUT, 255, max cycles waited in REQ+RESP before an access is aborted with error
TO_CNT_W, 8, width of timeout counter (must hold BUS_TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
acess_mem_flag_i  in  1  registered access flag from upstream pipeline register
inst_i  in  32  instruction; [6:0] opcode (0000011 load, 0100011 store), [14:12] funct3
alu_res_i  in  32  effective address (mem ops) or result (others)
rs2_data_i  in  32  store data
flush_i  in  1  pipeline refresh; cancels current access
mem_req_o  out  1  bus request
mem_we_o  out  1  1=store
mem_addr_o  out  32  word-aligned address {alu_res_i[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-shifted store data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  load response valid
mem_rdata_i  in  32  load response word
stall_o  out  1  holds upstream stages (drives FLOW_STOP)
rd_data_o  out  32  writeback data
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- FSM: IDLE, REQ, RESP, DONE. Reset → IDLE. Reset mid-access discards everything.
- Output reset values:
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0
  - load_q=0, bus_err_o=0, timeout counter=0
- IDLE:
  - If acess_mem_flag_i=1 and flush_i=0 → REQ; latch addr, be, wdata, we, funct3, byte offset.
  - stall_o=1 combinationally from that same cycle.
- REQ:
  - mem_req_o=1 and all bus fields held stable until gnt.
  - gnt with store → DONE. gnt with load → RESP.
  - gnt and rvalid in the same cycle for a load → capture data, → DONE.
- RESP:
  - mem_req_o=0. On rvalid: load_q = extended data, → DONE.
- DONE:
  - stall_o=0 for exactly one cycle so the upstream register advances → IDLE.
  - An access presented in this cycle is the same instruction and is not reissued.
- stall_o = (state==IDLE & acess_mem_flag_i & !flush_i) | state==REQ | state==RESP.
- Byte enables (off = alu_res_i[1:0]):
  - B: 1<<off
  - H: 0011<<off
  - W: 1111
- Store data: B replicated ×4; H replicated ×2; W as-is.
- Load extract: byte/half selected by off.
  - funct3 000/001 sign-extend; 100/101 zero-extend; 010 full word.
- rd_data_o = load_q when the current access is a load and state==DONE; otherwise alu_res_i (combinational).
- Timeout:
  - Counter clears on entry to REQ and increments every REQ/RESP cycle.
  - When it equals BUS_TIMEOUT: drop req, load_q=0, bus_err_o=1 for one cycle, → DONE.
- Flush:
  - In REQ without gnt: drop req → IDLE, stall_o=0 next cycle.
  - In REQ with gnt on a load, or in RESP: must still await rvalid (or timeout), discard data, → IDLE, no DONE cycle.
  - In DONE: → IDLE.
- Misaligned H/W addresses are issued as-is (truncated address) unless the feature below is enabled.

Optional Feature:
- Macro: AS_LSU_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit).
  - H with off[0]=1, or W with off!=0, issues no bus request.
  - Goes IDLE→DONE directly; misalign_o pulses 1 cycle in DONE; rd_data_o=0.
- When undefined: no port, no check.

Decomposition:
- Shared defines header (with existing FLOW/RESCTRL defines) gets:
  - opcode constants INST_TYPE_IL, INST_TYPE_S
  - funct3 constants LS_B, LS_H, LS_W, LS_BU, LS_HU
  - as_lsu state encodings
- One sub-module: as_lsu_align — combinational be/wdata generation and load extraction/extension. FSM, counter and handshake stay in as_lsu.

Test Plan:
- SW at alu_res=0x104, rs2=0xDEADBEEF, gnt after 2 cycles → mem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1, stall high 3 cycles then DONE.
- LB at 0x203, rdata=0x80FF_0000 → be=1000, rd_data_o=0xFFFFFF80. LBU same → 0x00000080.
- SH at 0x102, rs2=0x1234ABCD → be=1100, wdata=0xABCDABCD. LH at 0x102, rdata=0x7FFF0000 → 0x00007FFF.
- Load, gnt immediate, rvalid never → bus_err_o pulse after 255 cycles, rd_data_o=0, stall released.
- flush_i in REQ before gnt → req drops next cycle, no DONE. flush_i in RESP → waits rvalid, returns IDLE, rd_data unchanged.
- With AS_LSU_MISALIGN_CHECK_EN, LW at 0x101 → mem_req_o stays 0, misalign_o pulses, 1-cycle stall.

Source files
------------

// File: rtl/as_lsu_pkg.sv
// as_lsu_pkg: shared pipeline defines (flow/result control, load/store decode, LSU states)
package as_lsu_pkg;
  localparam logic FLOW_GO   = 1'b0;
  localparam logic FLOW_STOP = 1'b1;
  localparam logic [1:0] RESCTRL_ALU = 2'd0;
  localparam logic [1:0] RESCTRL_MEM = 2'd1;
  localparam logic [6:0] INST_TYPE_IL = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S  = 7'b0100011;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  typedef enum logic [1:0] {LSU_IDLE = 2'd0, LSU_REQ = 2'd1, LSU_RESP = 2'd2, LSU_DONE = 2'd3} lsu_state_e;
endpackage

// File: rtl/as_lsu_align.sv
// as_lsu_align: byte-enable/store-lane generation and load extraction with sign/zero extension
module as_lsu_align import as_lsu_pkg::*; (
  input  logic [1:0]  sz_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);
  logic [15:0] lane;
  always_comb begin
    be_o    = sz_i == LS_B[1:0] ? 4'b0001 << off_i : sz_i == LS_H[1:0] ? 4'b0011 << off_i : 4'b1111;
    wdata_o = sz_i == LS_B[1:0] ? {4{sdata_i[7:0]}} : sz_i == LS_H[1:0] ? {2{sdata_i[15:0]}} : sdata_i;
    lane    = 16'(rdata_i >> {ld_off_i, 3'b000});
    ldata_o = ld_funct3_i == LS_B  ? {{24{lane[7]}}, lane[7:0]} :
              ld_funct3_i == LS_H  ? {{16{lane[15]}}, lane} :
              ld_funct3_i == LS_BU ? {24'b0, lane[7:0]} :
              ld_funct3_i == LS_HU ? {16'b0, lane} : rdata_i;
  end
endmodule

// File: rtl/as_lsu.sv
// as_lsu: memory-access stage with req/gnt/rvalid bus handshake, pipeline stall and bus timeout.
// Optional AS_LSU_MISALIGN_CHECK_EN adds misalign_o and suppresses misaligned H/W bus accesses.
module as_lsu import as_lsu_pkg::*; #(
  parameter int CPU_WIDTH   = 32,
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acess_mem_flag_i,
  input  logic [31:0]          inst_i,
  input  logic [CPU_WIDTH-1:0] alu_res_i,
  input  logic [CPU_WIDTH-1:0] rs2_data_i,
  input  logic                 flush_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i,
  output logic                 stall_o,
  output logic [CPU_WIDTH-1:0] rd_data_o,
  output logic                 bus_err_o
`ifdef AS_LSU_MISALIGN_CHECK_EN
  , output logic               misalign_o
`endif
);
  lsu_state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d, ld_q, ld_d, err_q, err_d, fpend_q, fpend_d, mis_q, mis_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
  logic [3:0] be_q, be_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] be_w;
  logic [31:0] wdata_w, ext_w;
  logic is_ld, is_st, start, fl, tmo, mis_w, unused;
  assign is_ld  = inst_i[6:0] == INST_TYPE_IL;
  assign is_st  = inst_i[6:0] == INST_TYPE_S;
  assign start  = acess_mem_flag_i & !flush_i;
  assign fl     = fpend_q | flush_i;
  assign tmo    = cnt_q == TO_CNT_W'(BUS_TIMEOUT);
  assign unused = ^{inst_i[31:15], inst_i[11:7]};
`ifdef AS_LSU_MISALIGN_CHECK_EN
  assign mis_w = (is_ld | is_st) & ((inst_i[13:12] == LS_H[1:0] & alu_res_i[0]) |
                                    (inst_i[13:12] == LS_W[1:0] & |alu_res_i[1:0]));
  assign misalign_o = mis_q;
`else
  assign mis_w = 1'b0;
`endif
  as_lsu_align u_align (
    .sz_i        (inst_i[13:12]),
    .off_i       (alu_res_i[1:0]),
    .sdata_i     (rs2_data_i),
    .be_o        (be_w),
    .wdata_o     (wdata_w),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (mem_rdata_i),
    .ldata_o     (ext_w)
  );
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    ld_d    = ld_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    fpend_d = fpend_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      LSU_IDLE: if (start) begin
        addr_d  = {alu_res_i[31:2], 2'b00};
        be_d    = be_w;
        wdata_d = wdata_w;
        we_d    = is_st;
        ld_d    = is_ld;
        f3_d    = inst_i[14:12];
        off_d   = alu_res_i[1:0];
        cnt_d   = '0;
        fpend_d = 1'b0;
        req_d   = !mis_w;
        mis_d   = mis_w;
        state_d = mis_w ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ, LSU_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (tmo) begin
          req_d   = 1'b0;
          load_d  = '0;
          err_d   = 1'b1;
          state_d = fl ? LSU_IDLE : LSU_DONE;
        end else if (state_q == LSU_REQ && !mem_gnt_i) begin
          req_d   = flush_i ? 1'b0 : req_q;
          state_d = flush_i ? LSU_IDLE : LSU_REQ;
        end else if (state_q == LSU_REQ && !ld_q) begin
          req_d   = 1'b0;
          state_d = flush_i ? LSU_IDLE : LSU_DONE;
        end else if (mem_rvalid_i) begin
          // a flushed load still consumes its response, but the data is dropped
          req_d   = 1'b0;
          load_d  = fl ? load_q : ext_w;
          state_d = fl ? LSU_IDLE : LSU_DONE;
        end else begin
          req_d   = 1'b0;
          fpend_d = fl;
          state_d = LSU_RESP;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      fpend_q <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      fpend_q <= fpend_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign bus_err_o   = err_q;
  assign stall_o     = (state_q == LSU_IDLE & start) | state_q == LSU_REQ | state_q == LSU_RESP;
  assign rd_data_o   = state_q == LSU_DONE & mis_q ? '0 :
                       state_q == LSU_DONE & ld_q ? load_q : alu_res_i;
endmodule

// File: tb/tb_as_lsu.sv
// tb_as_lsu: randomized self-checking bench for as_lsu against a behavioural load/store model
module tb_as_lsu;
  logic clk = 1'b0;
  logic rst, flag, flush, gnt, rvalid;
  logic [31:0] inst, alu, rs2, rdata;
  logic mem_req_o, mem_we_o, stall_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rd_data_o;
  logic [3:0] mem_be_o;
`ifdef AS_LSU_MISALIGN_CHECK_EN
  logic misalign_o;
`endif
  int checks = 0, errors = 0;
  logic [31:0] last_be, last_wd, last_rd;
  logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  as_lsu dut (
    .clk(clk), .rst(rst), .acess_mem_flag_i(flag), .inst_i(inst), .alu_res_i(alu),
    .rs2_data_i(rs2), .flush_i(flush), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .stall_o(stall_o),
    .rd_data_o(rd_data_o), .bus_err_o(bus_err_o)
`ifdef AS_LSU_MISALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    int sz = int'(f3) % 4;
    int m = sz == 2 ? 15 : (sz == 0 ? 1 : 3) << off;
    return 4'(m % 16);
  endfunction
  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    int sz = int'(f3) % 4;
    return sz == 0 ? d[7:0] * 32'h01010101 : sz == 1 ? d[15:0] * 32'h00010001 : d;
  endfunction
  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v = rd >> (8 * off);
    int b = int'(v % 256);
    int h = int'(v % 65536);
    case (f3)
      3'b000:  return b >= 128 ? 32'(b - 256) : 32'(b);
      3'b001:  return h >= 32768 ? 32'(h - 65536) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return rd;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_inst(input bit st, input logic [2:0] f3);
    inst = $urandom;
    inst[14:12] = f3;
    inst[6:0] = st ? 7'b0100011 : 7'b0000011;
  endtask
  // rvd < 0 on a load means the response never arrives
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int gd, input int rvd);
    int n = 1, reqc = 0, since = 0;
    bit seen = 0;
    bit tmo = !st && rvd < 0;
    set_inst(st, f3);
    alu = a; rs2 = d; rdata = rd; flag = 1; flush = 0; gnt = 0; rvalid = 0;
    #1 chk("stall_start", stall_o, 1);
    while (1) begin
      tick;
      if (!stall_o) break;
      n++;
      if (n > 400) begin
        chk("wait_budget", n, 0);
        break;
      end
      if (mem_req_o) begin
        if (!seen) begin
          seen = 1;
          last_be = mem_be_o;
          last_wd = mem_wdata_o;
          chk("addr", mem_addr_o, {a[31:2], 2'b00});
          chk("be", mem_be_o, m_be(f3, a[1:0]));
          chk("we", mem_we_o, st);
          if (st) chk("wdata", mem_wdata_o, m_wd(f3, d));
        end
        gnt = reqc == gd;
        rvalid = gnt && !st && rvd == 0;
        reqc++;
      end else begin
        gnt = 0;
        since++;
        rvalid = rvd >= 0 && since >= rvd;
      end
    end
    gnt = 0; rvalid = 0;
    last_rd = rd_data_o;
    chk("rd_data", rd_data_o, st ? a : tmo ? 32'h0 : m_ld(f3, a[1:0], rd));
    chk("bus_err", bus_err_o, tmo);
    chk("stall_cycles", n, tmo ? 257 : 2 + gd + (st ? 0 : rvd));
    flag = 0; alu = $urandom;
    tick;
    chk("idle_req", mem_req_o, 0);
    chk("idle_err", bus_err_o, 0);
    chk("idle_stall", stall_o, 0);
    chk("passthru", rd_data_o, alu);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1; flag = 0; flush = 0; gnt = 0; rvalid = 0; inst = 0; alu = 32'h55; rs2 = 0; rdata = 0;
    repeat (3) tick;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_rd", rd_data_o, 32'h55);
    rst = 0;
    tick;
    access(1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 1, 0);
    chk("sw_be", last_be, 32'hF);
    chk("sw_wd", last_wd, 32'hDEADBEEF);
    access(0, 3'b000, 32'h203, 0, 32'h80FF0000, 0, 1);
    chk("lb_be", last_be, 32'h8);
    chk("lb_val", last_rd, 32'hFFFFFF80);
    access(0, 3'b100, 32'h203, 0, 32'h80FF0000, 1, 2);
    chk("lbu_val", last_rd, 32'h00000080);
    access(1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0);
    chk("sh_be", last_be, 32'hC);
    chk("sh_wd", last_wd, 32'hABCDABCD);
    access(0, 3'b001, 32'h102, 0, 32'h7FFF0000, 0, 0);
    chk("lh_val", last_rd, 32'h00007FFF);
    access(0, 3'b010, 32'h400, 0, 0, 0, -1);
    chk("tmo_rd", last_rd, 0);
    // flush while waiting for grant
    set_inst(1, 3'b010); alu = 32'h500; rs2 = 32'h1; flag = 1;
    tick;
    chk("fl_req_up", mem_req_o, 1);
    flush = 1;
    tick;
    chk("fl_req_drop", mem_req_o, 0);
    chk("fl_req_stall", stall_o, 0);
    flush = 0; flag = 0; alu = 32'h600;
    tick;
    chk("fl_req_idle", mem_req_o, 0);
    chk("fl_req_nodone", rd_data_o, 32'h600);
    // flush while waiting for the load response
    set_inst(0, 3'b010); alu = 32'h300; flag = 1;
    tick;
    gnt = 1;
    tick;
    gnt = 0; flush = 1; flag = 0; alu = 32'h777;
    tick;
    flush = 0;
    chk("fl_resp_wait", stall_o, 1);
    tick;
    chk("fl_resp_wait2", stall_o, 1);
    rvalid = 1; rdata = 32'h12345678;
    tick;
    rvalid = 0;
    chk("fl_resp_stall", stall_o, 0);
    chk("fl_resp_req", mem_req_o, 0);
    chk("fl_resp_rd", rd_data_o, 32'h777);
    chk("fl_resp_err", bus_err_o, 0);
    tick;
    chk("fl_resp_rd2", rd_data_o, 32'h777);
    // reset in the middle of an access
    set_inst(1, 3'b010); alu = 32'h900; flag = 1;
    tick;
    rst = 1; flag = 0;
    tick;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    rst = 0;
    tick;
`ifdef AS_LSU_MISALIGN_CHECK_EN
    set_inst(0, 3'b010); alu = 32'h101; flag = 1;
    #1 chk("mis_stall", stall_o, 1);
    tick;
    chk("mis_req", mem_req_o, 0);
    chk("mis_pulse", misalign_o, 1);
    chk("mis_rd", rd_data_o, 0);
    chk("mis_release", stall_o, 0);
    flag = 0;
    tick;
    chk("mis_clear", misalign_o, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      bit st = 1'($urandom_range(0, 1));
      logic [2:0] f3 = st ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
      logic [31:0] a = $urandom;
`ifdef AS_LSU_MISALIGN_CHECK_EN
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
`endif
      access(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
